sprite_palette_arbiter: RTL and testbench

//  Shares one combinational 16-entry sprite palette lookup among NUM_REQ sprite

---
 rtl/sprite_palette_arbiter_pkg.sv | 14 +
 rtl/sprite_palette_arbiter_rr_arbiter.sv | 46 ++++
 rtl/sprite_palette_arbiter.sv | 80 ++++++++
 tb/tb_sprite_palette_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_arbiter_pkg.sv
// Shared constants and types for the sprite palette arbiter slice.
package sprite_palette_arbiter_pkg;

    localparam int NUM_REQ         = 4;
    localparam int IDX_W           = 4;
    localparam int TRANSPARENT_IDX = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage

// File: rtl/sprite_palette_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);
    import sprite_palette_arbiter_pkg::*;

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned cand;
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (enable && !grant_valid && req[cand[PW-1:0]]) begin
                grant[cand[PW-1:0]] = 1'b1;
                grant_idx           = cand[PW-1:0];
                grant_valid         = 1'b1;
            end
        end
    end

    // Pointer moves past the winner so it becomes lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Shares one external palette lookup among NUM_REQ sprite requesters, registered RGB response.
module sprite_palette_arbiter #(
    parameter int NUM_REQ         = sprite_palette_arbiter_pkg::NUM_REQ,
    parameter int IDX_W           = sprite_palette_arbiter_pkg::IDX_W,
    parameter int TRANSPARENT_IDX = sprite_palette_arbiter_pkg::TRANSPARENT_IDX
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]   req_index,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IDX_W-1:0]           pal_index,
    input  logic [3:0]                 pal_red,
    input  logic [3:0]                 pal_green,
    input  logic [3:0]                 pal_blue,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [3:0]                 rsp_red,
    output logic [3:0]                 rsp_green,
    output logic [3:0]                 rsp_blue,
    output logic                       rsp_transp
);
    import sprite_palette_arbiter_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic            can_accept;
    logic            arb_enable;
    logic            grant_valid;
    logic [ID_W-1:0] grant_idx;
    rgb12_t          pal_rgb;
    rgb12_t          rsp_rgb;

    assign can_accept = !rsp_valid || rsp_ready;
    // Reset gates the arbiter so no request is reported accepted while in reset.
    assign arb_enable = can_accept && !Reset;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk         (Clk),
        .rst         (Reset),
        .req         (req_valid),
        .enable      (arb_enable),
        .grant       (req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        pal_index = '0;
        if (grant_valid) begin
            pal_index = req_index[grant_idx*IDX_W +: IDX_W];
        end
    end

    assign pal_rgb = '{r: pal_red, g: pal_green, b: pal_blue};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rgb    <= '0;
            rsp_transp <= 1'b0;
        end else if (grant_valid) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_rgb    <= pal_rgb;
            rsp_transp <= (pal_index == IDX_W'(TRANSPARENT_IDX));
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    assign rsp_red   = rsp_rgb.r;
    assign rsp_green = rsp_rgb.g;
    assign rsp_blue  = rsp_rgb.b;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed and randomized bench for sprite_palette_arbiter with an external palette model.
module tb_sprite_palette_arbiter;

    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [N-1:0] req_valid;
    logic [N*4-1:0] req_index;
    logic [N-1:0] req_ready;
    logic [3:0]   pal_index;
    logic [3:0]   pal_red, pal_green, pal_blue;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [3:0]   rsp_red, rsp_green, rsp_blue;
    logic         rsp_transp;

    logic         v_a [N];
    logic [3:0]   i_a [N];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 Clk = ~Clk;

    sprite_palette_arbiter #(
        .NUM_REQ         (N),
        .IDX_W           (4),
        .TRANSPARENT_IDX (0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_ready  (req_ready),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_red    (rsp_red),
        .rsp_green  (rsp_green),
        .rsp_blue   (rsp_blue),
        .rsp_transp (rsp_transp)
    );

    function automatic logic [11:0] pal_f(input logic [3:0] i);
        case (i)
            4'd0:    return 12'hF0D;
            4'd4:    return 12'h000;
            4'd8:    return 12'hEEE;
            default: return {i, i ^ 4'hA, ~i};
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_valid[k]         = v_a[k];
            req_index[k*4 +: 4]  = i_a[k];
        end
    end

    always_comb {pal_red, pal_green, pal_blue} = pal_f(pal_index);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input int id,
                             input logic [11:0] rgb, input logic t);
        check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        check({tag, "_id"},    32'(rsp_id), 32'(id));
        check({tag, "_rgb"},   32'({rsp_red, rsp_green, rsp_blue}), 32'(rgb));
        check({tag, "_transp"}, 32'(rsp_transp), 32'(t));
    endtask

    int          ptr;
    int          g;
    logic        e_valid;
    int          e_id;
    logic [11:0] e_rgb;
    logic        e_t;
    int          waits [N];

    initial begin
        // T1: reset with every requester valid
        Reset     = 1'b1;
        rsp_ready = 1'b1;
        v_a = '{1'b1, 1'b1, 1'b1, 1'b1};
        i_a = '{4'd0, 4'd4, 4'd2, 4'd8};
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check_rsp("rst_rsp", 1'b0, 0, 12'h000, 1'b0);
        end
        Reset = 1'b0;
        #1;
        check("first_grant", 32'(req_ready), 32'b0001);
        check("first_pal_index", 32'(pal_index), 32'd0);

        // T3: all valid, ids rotate 0,1,2,3,0
        tick();
        check_rsp("rr0", 1'b1, 0, 12'hF0D, 1'b1);
        check("rr_next_grant", 32'(req_ready), 32'b0010);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_rsp("rr_seq", 1'b1, k % 4, pal_f(i_a[k % 4]), i_a[k % 4] == 4'd0);
        end

        // T4: back-pressure holds everything, pointer preserved
        rsp_ready = 1'b0;
        #1;
        check("bp_no_grant", 32'(req_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_rsp("bp_hold", 1'b1, 0, 12'hF0D, 1'b1);
            check("bp_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_resume", 32'(req_ready), 32'b0010);
        tick();
        check_rsp("bp_resume_rsp", 1'b1, 1, 12'h000, 1'b0);

        // T5: reset while a response is stalled
        rsp_ready = 1'b0;
        Reset     = 1'b1;
        tick();
        check_rsp("rst_drop", 1'b0, 0, 12'h000, 1'b0);
        Reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rst_ptr_zero", 32'(req_ready), 32'b0001);

        // T2: lone requester 2 with index 8
        Reset = 1'b1;
        v_a   = '{1'b0, 1'b0, 1'b1, 1'b0};
        i_a   = '{4'd0, 4'd0, 4'd8, 4'd0};
        tick();
        Reset = 1'b0;
        #1;
        check("solo_grant", 32'(req_ready), 32'b0100);
        check("solo_pal_index", 32'(pal_index), 32'd8);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_rsp("solo_rsp", 1'b1, 2, 12'hEEE, 1'b0);
            check("solo_every_cycle", 32'(req_ready), 32'b0100);
        end

        // T6: random traffic against a reference model
        Reset = 1'b1;
        v_a   = '{1'b0, 1'b0, 1'b0, 1'b0};
        tick();
        Reset   = 1'b0;
        ptr     = 0;
        e_valid = 1'b0;
        e_id    = 0;
        e_rgb   = '0;
        e_t     = 1'b0;
        for (int k = 0; k < N; k++) waits[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(e_valid));
            if (e_valid) begin
                check("rnd_rsp_id", 32'(rsp_id), 32'(e_id));
                check("rnd_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(e_rgb));
                check("rnd_rsp_transp", 32'(rsp_transp), 32'(e_t));
            end
            for (int k = 0; k < N; k++) begin
                if (!v_a[k] && $urandom_range(0, 1) == 1) begin
                    v_a[k] = 1'b1;
                    i_a[k] = 4'($urandom_range(0, 15));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!e_valid || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && v_a[(ptr + k) % N]) g = (ptr + k) % N;
                end
            end
            check("rnd_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            check("rnd_pal_index", 32'(pal_index), (g >= 0) ? 32'(i_a[g]) : 32'd0);
            if (g >= 0) begin
                e_valid = 1'b1;
                e_id    = g;
                e_rgb   = pal_f(i_a[g]);
                e_t     = (i_a[g] == 4'd0);
                ptr     = (g + 1) % N;
                for (int k = 0; k < N; k++) begin
                    if (k != g && v_a[k]) begin
                        waits[k]++;
                        check("rnd_starvation", 32'(waits[k] < N), 32'd1);
                    end
                end
                waits[g] = 0;
            end else if (e_valid && rsp_ready) begin
                e_valid = 1'b0;
            end
            @(posedge Clk);
            #1;
            if (g >= 0) v_a[g] = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
